// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: shared frame states, PS/2 prefix bytes and game key codes
package ps2_pkg;
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes raw ps2_clk, rejects glitches and pulses on each filtered falling edge
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ps2_clk,
   output logic o_lvl,
   output logic o_fall_en
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_lvl;
   logic          r_lvl_d;
   // the filtered level only follows the synced line after FILTER_LEN consecutive differing samples
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync  <= 2'b11;
         r_cnt   <= '0;
         r_lvl   <= 1'b1;
         r_lvl_d <= 1'b1;
      end else begin
         r_sync  <= {r_sync[0], i_ps2_clk};
         r_lvl_d <= r_lvl;
         if (r_sync[1] == r_lvl)
            r_cnt <= '0;
         else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_lvl <= r_sync[1];
            r_cnt <= '0;
         end else
            r_cnt <= r_cnt + 1'b1;
      end
   end
   assign o_lvl     = r_lvl;
   assign o_fall_en = r_lvl_d & ~r_lvl;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: deserializes PS/2 frames and presents the held key's make code
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic [7:0] o_key,
   output logic       o_ext,
   output logic       o_key_valid,
   output logic       o_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]    r_dsync;
   logic          w_dat;
   logic          w_fall;
   logic          w_lvl;
   state_t        r_state;
   state_t        w_state_n;
   logic [2:0]    r_bit;
   logic [2:0]    w_bit_n;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_n;
   logic          r_par_ok;
   logic          w_par_ok_n;
   logic [TW-1:0] r_tmo;
   logic          w_tmo;
   logic          w_byte_done;
   logic          w_err;
   logic          r_ext_flag;
   logic          r_brk_flag;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_ps2_clk(i_ps2_clk),
      .o_lvl    (w_lvl),
      .o_fall_en(w_fall)
   );

   assign w_dat = r_dsync[1];
   assign w_tmo = (r_state != S_IDLE) && !w_fall && (r_tmo == TW'(TIMEOUT_CYCLES));

   // plain two-flop synchronizer for the data line, idling high like the bus
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_dsync <= 2'b11;
      else       r_dsync <= {r_dsync[0], i_ps2_dat};
   end

   // saturating count of cycles since the last falling edge, held at zero while idle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                r_tmo <= '0;
      else if (w_fall || r_state == S_IDLE)     r_tmo <= '0;
      else if (r_tmo != TW'(TIMEOUT_CYCLES))    r_tmo <= r_tmo + 1'b1;
   end

   // frame state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_bit    <= '0;
         r_shift  <= '0;
         r_par_ok <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_bit    <= w_bit_n;
         r_shift  <= w_shift_n;
         r_par_ok <= w_par_ok_n;
      end
   end

   // frame sequencing: a timeout abandons the frame, otherwise advance one bit per falling edge
   always_comb begin
      w_state_n   = r_state;
      w_bit_n     = r_bit;
      w_shift_n   = r_shift;
      w_par_ok_n  = r_par_ok;
      w_byte_done = 1'b0;
      w_err       = 1'b0;
      if (w_tmo) begin
         w_state_n = S_IDLE;
         w_err     = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            S_IDLE: begin
               w_err     = w_dat;
               w_state_n = w_dat ? S_IDLE : S_DATA;
               w_bit_n   = '0;
            end
            S_DATA: begin
               w_shift_n = {w_dat, r_shift[7:1]};
               w_bit_n   = r_bit + 3'd1;
               w_state_n = (r_bit == 3'd7) ? S_PARITY : S_DATA;
            end
            S_PARITY: begin
               w_par_ok_n = ^{r_shift, w_dat};
               w_state_n  = S_STOP;
            end
            S_STOP: begin
               w_byte_done = w_dat & r_par_ok;
               w_err       = ~(w_dat & r_par_ok);
               w_state_n   = S_IDLE;
            end
            default: w_state_n = S_IDLE;
         endcase
      end
   end

   // decode prefixes, track the held key and register the one-cycle pulses
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_key       <= 8'h00;
         o_ext       <= 1'b0;
         o_key_valid <= 1'b0;
         o_err       <= 1'b0;
         r_ext_flag  <= 1'b0;
         r_brk_flag  <= 1'b0;
      end else begin
         o_key_valid <= 1'b0;
         o_err       <= w_err;
         if (w_tmo) begin
            r_ext_flag <= 1'b0;
            r_brk_flag <= 1'b0;
         end else if (w_byte_done) begin
            if (r_shift == PS2_EXT)
               r_ext_flag <= 1'b1;
            else if (r_shift == PS2_BRK)
               r_brk_flag <= 1'b1;
            else begin
               r_ext_flag <= 1'b0;
               r_brk_flag <= 1'b0;
               if (!r_brk_flag) begin
                  o_key       <= r_shift;
                  o_ext       <= r_ext_flag;
                  o_key_valid <= 1'b1;
               end else if (r_shift == o_key && r_ext_flag == o_ext) begin
                  o_key <= 8'h00;
                  o_ext <= 1'b0;
               end
            end
         end
      end
   end

   logic w_unused;
   assign w_unused = w_lvl;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: drives PS/2 frames and checks decoded keys against a byte-level model
module tb_ps2_key_decoder;
   import ps2_pkg::*;
   localparam int HALF = 15;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] key;
   logic       ext;
   logic       kv;
   logic       err;
   int         checks = 0;
   int         failures = 0;
   int         n_valid = 0;
   int         n_err = 0;
   bit         both_seen = 0;
   logic [7:0] m_key = 8'h00;
   logic       m_ext = 1'b0;
   logic       m_eflag = 1'b0;
   logic       m_bflag = 1'b0;
   int         m_valid = 0;

   ps2_key_decoder dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_ps2_clk  (ps2_clk),
      .i_ps2_dat  (ps2_dat),
      .o_key      (key),
      .o_ext      (ext),
      .o_key_valid(kv),
      .o_err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (kv) n_valid++;
      if (err) n_err++;
      if (kv && err) both_seen = 1;
   end

   task automatic send_bit(input bit v, input bit g);
      @(negedge clk) ps2_dat = v;
      if (g) begin
         repeat (4) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (HALF - 7) @(negedge clk);
      end else
         repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit g);
      send_bit(1'b0, g);
      for (int i = 0; i < 8; i++) send_bit(b[i], g);
      send_bit((~^b) ^ bad_par, g);
      send_bit(1'b1, g);
      ps2_dat = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == PS2_EXT) m_eflag = 1'b1;
      else if (b == PS2_BRK) m_bflag = 1'b1;
      else begin
         if (!m_bflag) begin
            m_key = b;
            m_ext = m_eflag;
            m_valid++;
         end else if (b == m_key && m_eflag == m_ext) begin
            m_key = 8'h00;
            m_ext = 1'b0;
         end
         m_eflag = 1'b0;
         m_bflag = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0);
      model_byte(b);
   endtask

   task automatic check_state(input string name, input int dv, input int de, input int ev, input int ee);
      checks++;
      if (key !== m_key) begin
         failures++;
         $display("FAIL %s key got %h want %h", name, key, m_key);
      end
      checks++;
      if (ext !== m_ext) begin
         failures++;
         $display("FAIL %s ext got %b want %b", name, ext, m_ext);
      end
      checks++;
      if (dv !== ev) begin
         failures++;
         $display("FAIL %s valid pulses got %0d want %0d", name, dv, ev);
      end
      checks++;
      if (de !== ee) begin
         failures++;
         $display("FAIL %s err pulses got %0d want %0d", name, de, ee);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({key, ext, kv, err} !== 11'd0) begin
         failures++;
         $display("FAIL reset outputs got %h/%b/%b/%b want 00/0/0/0", key, ext, kv, err);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_state("reset_release", n_valid, n_err, 0, 0);
   endtask

   task automatic test_make_ext;
      int v0 = n_valid, e0 = n_err, mv0 = m_valid;
      send_byte(PS2_EXT);
      send_byte(KEY_UP);
      check_state("make_ext", n_valid - v0, n_err - e0, m_valid - mv0, 0);
      checks++;
      if (key !== 8'h75 || ext !== 1'b1) begin
         failures++;
         $display("FAIL make_ext_const got %h/%b want 75/1", key, ext);
      end
   endtask

   task automatic test_break;
      int v0 = n_valid, e0 = n_err;
      send_byte(PS2_EXT);
      send_byte(PS2_BRK);
      send_byte(KEY_UP);
      check_state("break", n_valid - v0, n_err - e0, 0, 0);
   endtask

   task automatic test_parity;
      int v0 = n_valid, e0 = n_err;
      send_frame(KEY_UP, 1'b1, 1'b0);
      check_state("parity_err", n_valid - v0, n_err - e0, 0, 1);
   endtask

   task automatic test_start_err;
      int v0 = n_valid, e0 = n_err;
      send_bit(1'b1, 1'b0);
      repeat (HALF) @(negedge clk);
      check_state("start_err", n_valid - v0, n_err - e0, 0, 1);
   endtask

   task automatic test_other_break;
      int v0 = n_valid, e0 = n_err;
      send_byte(PS2_EXT);
      send_byte(KEY_LEFT);
      send_byte(PS2_EXT);
      send_byte(PS2_BRK);
      send_byte(KEY_RIGHT);
      check_state("other_break", n_valid - v0, n_err - e0, 1, 0);
   endtask

   task automatic test_timeout;
      int v0, e0;
      send_byte(PS2_EXT);
      e0 = n_err;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      repeat (9950) @(negedge clk);
      checks++;
      if (n_err - e0 !== 0) begin
         failures++;
         $display("FAIL timeout_early err pulses got %0d want 0", n_err - e0);
      end
      repeat (150) @(negedge clk);
      checks++;
      if (n_err - e0 !== 1) begin
         failures++;
         $display("FAIL timeout_fire err pulses got %0d want 1", n_err - e0);
      end
      m_eflag = 1'b0;
      m_bflag = 1'b0;
      v0 = n_valid;
      e0 = n_err;
      send_byte(KEY_DOWN);
      check_state("after_timeout", n_valid - v0, n_err - e0, 1, 0);
   endtask

   task automatic test_rst_mid;
      int v0, e0;
      send_byte(KEY_RIGHT);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      checks++;
      if (key !== 8'h00 || ext !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid got %h/%b want 00/0", key, ext);
      end
      rst = 1'b0;
      ps2_dat = 1'b1;
      m_key = 8'h00;
      m_ext = 1'b0;
      m_eflag = 1'b0;
      m_bflag = 1'b0;
      repeat (5) @(negedge clk);
      v0 = n_valid;
      e0 = n_err;
      send_byte(KEY_LEFT);
      check_state("after_rst", n_valid - v0, n_err - e0, 1, 0);
   endtask

   task automatic test_glitch;
      int v0 = n_valid, e0 = n_err;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk) ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      check_state("glitch_idle", n_valid - v0, n_err - e0, 0, 0);
      v0 = n_valid;
      e0 = n_err;
      send_frame(8'h1C, 1'b0, 1'b1);
      model_byte(8'h1C);
      check_state("glitch_frame", n_valid - v0, n_err - e0, 1, 0);
   endtask

   task automatic test_back_to_back;
      int v0 = n_valid, e0 = n_err;
      send_byte(KEY_DOWN);
      send_byte(KEY_LEFT);
      send_byte(KEY_LEFT);
      check_state("typematic", n_valid - v0, n_err - e0, 3, 0);
   endtask

   task automatic test_random;
      logic [7:0] keys [6];
      logic [7:0] k;
      int v0, e0, mv0, ee;
      bit e, b;
      keys = '{KEY_UP, KEY_DOWN, KEY_RIGHT, KEY_LEFT, 8'h1C, 8'h29};
      for (int it = 0; it < 25; it++) begin
         v0 = n_valid;
         e0 = n_err;
         mv0 = m_valid;
         ee = 0;
         if ($urandom_range(0, 5) == 0) begin
            send_frame(keys[$urandom_range(0, 5)], 1'b1, 1'b0);
            ee = 1;
         end
         k = keys[$urandom_range(0, 5)];
         e = 1'($urandom_range(0, 1));
         b = ($urandom_range(0, 2) == 0);
         if (b && m_key != 8'h00 && $urandom_range(0, 1) == 1) begin
            k = m_key;
            e = m_ext;
         end
         if (e) send_byte(PS2_EXT);
         if (b) send_byte(PS2_BRK);
         send_byte(k);
         check_state("random", n_valid - v0, n_err - e0, m_valid - mv0, ee);
      end
   endtask

   task automatic test_exclusive;
      checks++;
      if (both_seen !== 1'b0) begin
         failures++;
         $display("FAIL exclusive valid_and_err got %b want 0", both_seen);
      end
   endtask

   initial begin
      test_reset;
      test_make_ext;
      test_break;
      test_parity;
      test_start_err;
      test_other_break;
      test_timeout;
      test_rst_mid;
      test_glitch;
      test_back_to_back;
      test_random;
      test_exclusive;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
